// File: rtl/reorder_buffer_if.sv
// Reorder buffer interface: dispatch, completion, head window and retire signals.
// Entry layout (EW bits): [0] complete, [1] is_branch, [2] branch_taken,
// [3 +: AW] branch_target, [3+AW +: PW] opaque payload.
interface reorder_buffer_if #(
    parameter int unsigned N     = 3,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 32,
    parameter int unsigned PW    = 16
);
    localparam int unsigned IDXW = $clog2(DEPTH);
    localparam int unsigned EW   = 3 + AW + PW;

    logic [N-1:0]            disp_valid;
    logic [N-1:0][EW-1:0]    disp_entries;
    logic [N-1:0][IDXW-1:0]  disp_idxs;
    logic [IDXW:0]           free_slots;
    logic [N-1:0]            cmpl_valid;
    logic [N-1:0][IDXW-1:0]  cmpl_idx;
    logic [N-1:0]            cmpl_branch_taken;
    logic [N-1:0][AW-1:0]    cmpl_branch_target;
    logic [N-1:0][EW-1:0]    head_entries;
    logic [N-1:0]            head_valids;
    logic [N-1:0][IDXW-1:0]  head_idxs;
    logic [N-1:0]            retire_valid;
    logic                    rob_mispredict;
    logic [IDXW-1:0]         rob_mispred_idx;

    modport master (
        output disp_valid, disp_entries, cmpl_valid, cmpl_idx, cmpl_branch_taken,
               cmpl_branch_target, retire_valid, rob_mispredict, rob_mispred_idx,
        input  disp_idxs, free_slots, head_entries, head_valids, head_idxs
    );

    modport slave (
        input  disp_valid, disp_entries, cmpl_valid, cmpl_idx, cmpl_branch_taken,
               cmpl_branch_target, retire_valid, rob_mispredict, rob_mispred_idx,
        output disp_idxs, free_slots, head_entries, head_valids, head_idxs
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: N-wide dispatch, completion and retire,
// with a retire-side mispredict that empties the buffer after the branch.
module reorder_buffer #(
    parameter int unsigned N     = 3,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 32,
    parameter int unsigned PW    = 16
) (
    input logic             clock,
    input logic             reset,
    reorder_buffer_if.slave rob
);
    localparam int unsigned IDXW     = $clog2(DEPTH);
    localparam int unsigned EW       = 3 + AW + PW;
    localparam int unsigned CmplBit  = 0;
    localparam int unsigned BrBit    = 1;
    localparam int unsigned TakenBit = 2;
    localparam int unsigned TgtLsb   = 3;

    logic [EW-1:0]          entries_q [DEPTH];
    logic [EW-1:0]          entries_d [DEPTH];
    logic [DEPTH-1:0]       valid_q, valid_d;
    logic [IDXW-1:0]        head_q, head_d, tail_q, tail_d;
    logic [IDXW:0]          count_q, count_d;

    logic [IDXW:0]          free_slots, disp_cnt, ret_cnt;
    logic                   disp_accept;
    logic [N-1:0][IDXW-1:0] disp_idxs;
    logic [N-1:0][IDXW-1:0] head_idxs;
    logic [N-1:0][EW-1:0]   head_entries;
    logic [N-1:0]           head_valids;

    // Free space is taken from registered count only; same-cycle retires are not credited.
    assign free_slots = (IDXW+1)'(DEPTH) - count_q;

    // Hand out consecutive indices from tail to valid lanes in ascending lane order.
    always_comb begin
        disp_cnt = '0;
        for (int w = 0; w < N; w++) begin
            disp_idxs[w] = tail_q + disp_cnt[IDXW-1:0];
            if (rob.disp_valid[w]) disp_cnt = disp_cnt + (IDXW+1)'(1);
        end
    end

    // Retire mask is a prefix, so its popcount is the number of entries freed.
    always_comb begin
        ret_cnt = '0;
        for (int w = 0; w < N; w++) begin
            if (rob.retire_valid[w]) ret_cnt = ret_cnt + (IDXW+1)'(1);
        end
    end

    // Whole dispatch group is dropped if it does not fit or a flush is in progress.
    assign disp_accept = (disp_cnt <= free_slots) && !rob.rob_mispredict;

    // Next state: completion, then retire, then dispatch (they touch disjoint slots).
    always_comb begin
        entries_d = entries_q;
        valid_d   = valid_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (rob.rob_mispredict) begin
            // The branch itself retires, everything younger is squashed.
            valid_d = '0;
            head_d  = rob.rob_mispred_idx + IDXW'(1);
            tail_d  = rob.rob_mispred_idx + IDXW'(1);
            count_d = '0;
        end else begin
            // Ascending lane order lets the higher lane win on a duplicate index.
            for (int w = 0; w < N; w++) begin
                if (rob.cmpl_valid[w] && valid_q[rob.cmpl_idx[w]]) begin
                    entries_d[rob.cmpl_idx[w]][CmplBit] = 1'b1;
                    if (entries_q[rob.cmpl_idx[w]][BrBit]) begin
                        entries_d[rob.cmpl_idx[w]][TakenBit]      = rob.cmpl_branch_taken[w];
                        entries_d[rob.cmpl_idx[w]][TgtLsb +: AW]  = rob.cmpl_branch_target[w];
                    end
                end
            end
            for (int w = 0; w < N; w++) begin
                if ((IDXW+1)'(w) < ret_cnt) valid_d[head_q + IDXW'(w)] = 1'b0;
            end
            head_d = head_q + ret_cnt[IDXW-1:0];
            if (disp_accept) begin
                for (int w = 0; w < N; w++) begin
                    if (rob.disp_valid[w]) begin
                        entries_d[disp_idxs[w]]          = rob.disp_entries[w];
                        entries_d[disp_idxs[w]][CmplBit] = 1'b0;
                        valid_d[disp_idxs[w]]            = 1'b1;
                    end
                end
                tail_d = tail_q + disp_cnt[IDXW-1:0];
            end
            count_d = count_q + (disp_accept ? disp_cnt : '0) - ret_cnt;
        end
    end

    // State register; reset clears bookkeeping and status bits, payloads are left as-is.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) entries_q[i][CmplBit] <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            entries_q <= entries_d;
        end
    end

    // Head window: the N oldest slots, valid while inside the occupied range.
    always_comb begin
        for (int w = 0; w < N; w++) begin
            head_idxs[w]    = head_q + IDXW'(w);
            head_entries[w] = entries_q[head_q + IDXW'(w)];
            head_valids[w]  = (IDXW+1)'(w) < count_q;
        end
    end

    assign rob.disp_idxs    = disp_idxs;
    assign rob.free_slots   = free_slots;
    assign rob.head_idxs    = head_idxs;
    assign rob.head_entries = head_entries;
    assign rob.head_valids  = head_valids;
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
Circular in-order reorder buffer that feeds the retire stage. Allocates up to N entries per cycle at dispatch and records execution completion and resolved branch outcome per entry. Presents the N oldest entries as a head window and frees entries as the retire stage commits them. On a retire-side mispredict it squashes all entries younger than the mispredicted branch.

Parameters:
N, `N, dispatch/complete/retire width.
DEPTH, `ROB_SZ, number of entries; power of two, DEPTH >= 2*N.
IDXW, $clog2(DEPTH), index width (ROB_IDX is IDXW bits).

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
disp_valid  input  N  dispatch lane valid; lanes need not be contiguous
disp_entries  input  N x ROB_ENTRY  new entries; complete field ignored and forced to 0
disp_idxs  output  N x ROB_IDX  index assigned to each valid lane this cycle (combinational)
free_slots  output  IDXW+1  DEPTH - count, from registered state
cmpl_valid  input  N  completion lane valid
cmpl_idx  input  N x ROB_IDX  entry completed
cmpl_branch_taken  input  N  resolved direction (branches only)
cmpl_branch_target  input  N x ADDR  resolved target (branches only)
head_entries  output  N x ROB_ENTRY  entries head+0 .. head+N-1, slot 0 oldest
head_valids  output  N  slot w valid iff w < count
head_idxs  output  N x ROB_IDX  (head+w) mod DEPTH
retire_valid  input  N  lanes committed this cycle; must be a prefix mask
rob_mispredict  input  1  flush younger than rob_mispred_idx
rob_mispred_idx  input  ROB_IDX  index of the mispredicted branch (itself retires)

Behaviour:
- State: entry array with per-entry valid; head, tail (IDXW bits, wrap mod DEPTH); count (IDXW+1 bits, 0..DEPTH).
- Reset: head = tail = count = 0; all valid and complete bits cleared; head_valids = 0; free_slots = DEPTH. Entry payloads are don't-care. Reset mid-operation discards all in-flight state next cycle.
- Dispatch: k = popcount(disp_valid). Valid lanes get consecutive indices tail, tail+1, ... in ascending lane order. disp_idxs for invalid lanes is don't-care.
  - Accepted only if k <= free_slots. free_slots does not credit same-cycle retires.
  - If k > free_slots, the whole group is dropped: no writes, no pointer change.
  - On accept: entries written with valid = 1 and complete = 0; tail += k.
- Completion: for each cmpl lane whose target entry is valid, set complete = 1. For branches, also write branch_taken/branch_target.
  - A completion to an invalid entry is ignored.
  - Two lanes to the same index: the higher lane wins.
  - Completion-to-head_entries latency is 1 cycle (registered).
- Retire: r = popcount(retire_valid). Entries head .. head+r-1 are invalidated; head += r.
  - retire_valid is only asserted on slots where head_valids = 1 and complete = 1. A bench assertion flags a non-prefix mask or retire of an invalid or incomplete slot.
- count_next = count + k_accepted - r.
- Mispredict (rob_mispredict = 1): the retire group that cycle ends with the branch, so the ROB becomes empty.
  - head = tail = rob_mispred_idx + 1 (mod DEPTH); count = 0; all valid bits cleared.
  - Same-cycle dispatch is dropped; same-cycle completions are ignored.
- Full (count = DEPTH): free_slots = 0; any dispatch is dropped. A same-cycle retire frees entries visible next cycle only.
- Empty: head_valids = 0; head_entries are don't-care.
- Wrap-around: allocation, head window, and retire indices wrap mod DEPTH seamlessly.
- Simultaneous dispatch + retire + completion in one cycle are all legal and independent, except under mispredict as above.

Test Plan:
- N=3, DEPTH=8: reset, then dispatch disp_valid=101 -> disp_idxs lane0=0, lane2=1; next cycle head_valids=011, head_idxs=0,1,2, free_slots=6.
- Fill to 8 entries, then dispatch 3 lanes -> group dropped, tail unchanged, free_slots=0. Retire 2 while dispatching 2 -> dispatch still dropped that cycle; accepted the following cycle.
- Entries 0,1,2 valid; complete idx 1 then idx 0 -> complete bits visible 1 cycle later. retire_valid=011 -> head=2, count=1, head_idxs=2,3,4.
- Wrap: head=6, count=0; dispatch 3 -> indices 6,7,0; retire 3 -> head=1, count=0.
- Entries 3..7 valid, branch at 4. rob_mispredict with idx 4, retire_valid=011, plus a same-cycle dispatch -> next cycle head=tail=5, count=0, head_valids=000, dispatch discarded.
- Reset asserted with count=5 -> next cycle count=0, free_slots=8, head_valids=000. A completion to a stale index is ignored.
